stopwatch_lap_recorder: RTL and testbench

//   Lap capture/replay stage between the stopwatch datapath and the FND controller.
//   - Snapshots the live msec/sec/min/hour time into a circular lap buffer on each debounced lap pulse.
//   - In LIVE mode it passes live time to the display. In VIEW mode it shows one stored lap, stepped with a next pulse.

---
 rtl/stopwatch_lap_recorder_pkg.sv | 16 +
 rtl/stopwatch_lap_recorder_regfile.sv | 31 +++
 rtl/stopwatch_lap_recorder.sv | 140 ++++++++++++++
 tb/tb_stopwatch_lap_recorder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_lap_recorder_pkg.sv
// Shared widths, default depth and FSM state type for the stopwatch lap recorder.
// Other stopwatch blocks import these widths so that every block agrees on the field layout.
package stopwatch_lap_recorder_pkg;

    localparam int unsigned DEFAULT_MSEC_W = 7;
    localparam int unsigned DEFAULT_SEC_W  = 6;
    localparam int unsigned DEFAULT_MIN_W  = 6;
    localparam int unsigned DEFAULT_HOUR_W = 5;
    localparam int unsigned DEFAULT_DEPTH  = 4;

    typedef enum logic {
        StLive = 1'b0,
        StView = 1'b1
    } lap_view_state_e;

endpackage

// File: rtl/stopwatch_lap_recorder_regfile.sv
// Lap storage: DEPTH x WIDTH register file with one synchronous write port and one
// combinational read port. The storage has no reset; unused slots are never displayed.
module stopwatch_lap_recorder_regfile #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stopwatch_lap_recorder.sv
// Lap capture/replay stage between the stopwatch datapath and the display controller.
// Captures live time into a circular lap buffer and shows either live time or one stored lap.
module stopwatch_lap_recorder
    import stopwatch_lap_recorder_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned MSEC_W = DEFAULT_MSEC_W,
    parameter int unsigned SEC_W  = DEFAULT_SEC_W,
    parameter int unsigned MIN_W  = DEFAULT_MIN_W,
    parameter int unsigned HOUR_W = DEFAULT_HOUR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_lap,
    input  logic                       i_next,
    input  logic                       i_clear,
    input  logic                       i_view,
    input  logic [MSEC_W-1:0]          i_msec,
    input  logic [SEC_W-1:0]           i_sec,
    input  logic [MIN_W-1:0]           i_min,
    input  logic [HOUR_W-1:0]          i_hour,
    output logic [MSEC_W-1:0]          o_msec,
    output logic [SEC_W-1:0]           o_sec,
    output logic [MIN_W-1:0]           o_min,
    output logic [HOUR_W-1:0]          o_hour,
    output logic [$clog2(DEPTH)-1:0]   o_lap_idx,
    output logic [$clog2(DEPTH):0]     o_lap_cnt,
    output logic                       o_viewing
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WORD_W = HOUR_W + MIN_W + SEC_W + MSEC_W;

    lap_view_state_e    state_q, state_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]  disp_q, disp_d;
    logic [IDX_W-1:0]   lap_idx_q;
    logic [CNT_W-1:0]   lap_cnt_q;
    logic               viewing_q;

    logic               full;
    logic               capture;
    logic [IDX_W-1:0]   oldest;
    logic [IDX_W-1:0]   rd_addr;
    logic [WORD_W-1:0]  live_word;
    logic [WORD_W-1:0]  rd_word;

    assign live_word = {i_hour, i_min, i_sec, i_msec};
    assign full      = (count_q == CNT_W'(DEPTH));
    assign capture   = i_lap & ~i_clear;
    assign oldest    = full ? wr_ptr_q : '0;
    // DEPTH is a power of two, so the adder wrap is the modulo.
    assign rd_addr   = oldest + rd_idx_q;

    stopwatch_lap_recorder_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_regfile (
        .clk_i   (clk),
        .we_i    (capture),
        .waddr_i (wr_ptr_q),
        .wdata_i (live_word),
        .raddr_i (rd_addr),
        .rdata_o (rd_word)
    );

    always_comb begin
        state_d  = i_view ? StView : StLive;
        wr_ptr_d = wr_ptr_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;

        if (state_q == StLive) begin
            if (i_view) begin
                rd_idx_d = '0;
            end
        end else if (i_next && (count_q != '0)) begin
            // Wrap decision uses the count before any same-cycle capture.
            rd_idx_d = ({1'b0, rd_idx_q} == count_q - 1'b1) ? '0 : rd_idx_q + 1'b1;
        end

        if (capture) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!full) begin
                count_d = count_q + 1'b1;
            end
        end

        if (i_clear) begin
            wr_ptr_d = '0;
            rd_idx_d = '0;
            count_d  = '0;
        end

        if (count_d == '0) begin
            rd_idx_d = '0;
        end else if ({1'b0, rd_idx_d} > count_d - 1'b1) begin
            rd_idx_d = IDX_W'(count_d - 1'b1);
        end

        if (state_q == StLive) begin
            disp_d = live_word;
        end else if (count_q == '0) begin
            disp_d = '0;
        end else begin
            disp_d = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLive;
            wr_ptr_q  <= '0;
            rd_idx_q  <= '0;
            count_q   <= '0;
            disp_q    <= '0;
            lap_idx_q <= '0;
            lap_cnt_q <= '0;
            viewing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_idx_q  <= rd_idx_d;
            count_q   <= count_d;
            disp_q    <= disp_d;
            lap_idx_q <= rd_idx_q;
            lap_cnt_q <= count_q;
            viewing_q <= (state_q == StView);
        end
    end

    assign {o_hour, o_min, o_sec, o_msec} = disp_q;
    assign o_lap_idx = lap_idx_q;
    assign o_lap_cnt = lap_cnt_q;
    assign o_viewing = viewing_q;

endmodule

// File: tb/tb_stopwatch_lap_recorder.sv
// Self-checking bench for stopwatch_lap_recorder: a behavioural model pushes the expected
// outputs on every clock edge; they are popped and compared half a cycle later.
module tb_stopwatch_lap_recorder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_lap = 1'b0, i_next = 1'b0, i_clear = 1'b0, i_view = 1'b0;
    logic [6:0] i_msec = '0;
    logic [5:0] i_sec = '0;
    logic [5:0] i_min = '0;
    logic [4:0] i_hour = '0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic [1:0] o_lap_idx;
    logic [2:0] o_lap_cnt;
    logic       o_viewing;

    int checks = 0;
    int failures = 0;

    stopwatch_lap_recorder dut (
        .clk       (clk),
        .rst       (rst),
        .i_lap     (i_lap),
        .i_next    (i_next),
        .i_clear   (i_clear),
        .i_view    (i_view),
        .i_msec    (i_msec),
        .i_sec     (i_sec),
        .i_min     (i_min),
        .i_hour    (i_hour),
        .o_msec    (o_msec),
        .o_sec     (o_sec),
        .o_min     (o_min),
        .o_hour    (o_hour),
        .o_lap_idx (o_lap_idx),
        .o_lap_cnt (o_lap_cnt),
        .o_viewing (o_viewing)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_out(bit v, int cnt, int idx, logic [23:0] w);
        return {2'b00, v, 3'(cnt), 2'(idx), w};
    endfunction

    // Behavioural model of the recorder, advanced on every rising edge.
    bit          m_view = 1'b0;
    int          m_cnt = 0, m_wr = 0, m_rd = 0;
    logic [23:0] m_mem [D];
    logic [31:0] exp_q [$];

    always @(posedge clk) begin
        logic [23:0] live, shown;
        int          oldest;
        live = {i_hour, i_min, i_sec, i_msec};
        if (rst) begin
            exp_q.push_back(32'h0);
            m_view = 1'b0;
            m_cnt  = 0;
            m_wr   = 0;
            m_rd   = 0;
        end else begin
            oldest = (m_cnt == D) ? m_wr : 0;
            if (!m_view)         shown = live;
            else if (m_cnt == 0) shown = '0;
            else                 shown = m_mem[(oldest + m_rd) % D];
            exp_q.push_back(pack_out(m_view, m_cnt, m_rd, shown));

            if (!m_view) begin
                if (i_view) m_rd = 0;
            end else if (i_next && m_cnt != 0) begin
                m_rd = (m_rd == m_cnt - 1) ? 0 : m_rd + 1;
            end
            if (i_lap && !i_clear) begin
                m_mem[m_wr] = live;
                m_wr  = (m_wr + 1) % D;
                m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
            end
            if (i_clear) begin
                m_cnt = 0;
                m_wr  = 0;
                m_rd  = 0;
            end
            if (m_cnt == 0) m_rd = 0;
            else if (m_rd > m_cnt - 1) m_rd = m_cnt - 1;
            m_view = i_view;
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_val("scoreboard",
                      {2'b00, o_viewing, o_lap_cnt, o_lap_idx, o_hour, o_min, o_sec, o_msec},
                      exp_q.pop_front());
        end
    end

    task automatic set_time(input int h, input int m, input int s, input int ms);
        i_hour = 5'(h);
        i_min  = 6'(m);
        i_sec  = 6'(s);
        i_msec = 7'(ms);
    endtask

    task automatic pulse(input bit lap, input bit nxt, input bit clr);
        i_lap   = lap;
        i_next  = nxt;
        i_clear = clr;
        @(negedge clk);
        i_lap   = 1'b0;
        i_next  = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        idle(2);
        check_val("rst_cnt", 32'(o_lap_cnt), 32'd0);
        check_val("rst_viewing", 32'(o_viewing), 32'd0);
        check_val("rst_msec", 32'(o_msec), 32'd0);
        rst = 1'b0;

        // Live pass-through
        set_time(0, 12, 34, 56);
        idle(1);
        check_val("live_min", 32'(o_min), 32'd12);
        check_val("live_sec", 32'(o_sec), 32'd34);
        check_val("live_msec", 32'(o_msec), 32'd56);

        // Three laps then view and step with wrap
        set_time(0, 0, 1, 10); pulse(1, 0, 0);
        set_time(0, 0, 2, 20); pulse(1, 0, 0);
        set_time(0, 0, 3, 30); pulse(1, 0, 0);
        i_view = 1'b1;
        idle(3);
        check_val("view_sec0", 32'(o_sec), 32'd1);
        check_val("view_msec0", 32'(o_msec), 32'd10);
        check_val("view_idx0", 32'(o_lap_idx), 32'd0);
        check_val("view_cnt3", 32'(o_lap_cnt), 32'd3);
        check_val("view_flag", 32'(o_viewing), 32'd1);
        pulse(0, 1, 0); idle(1);
        check_val("next_msec1", 32'(o_msec), 32'd20);
        pulse(0, 1, 0); idle(1);
        check_val("next_msec2", 32'(o_msec), 32'd30);
        pulse(0, 1, 0); idle(1);
        check_val("next_wrap", 32'(o_msec), 32'd10);

        // Overwrite of the oldest lap when full
        i_view = 1'b0;
        pulse(0, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            set_time(0, 0, 10 + k, k);
            pulse(1, 0, 0);
        end
        i_view = 1'b1;
        idle(3);
        check_val("full_cnt", 32'(o_lap_cnt), 32'd4);
        check_val("full_oldest", 32'(o_sec), 32'd12);
        for (int k = 3; k <= 5; k++) begin
            pulse(0, 1, 0); idle(1);
            check_val("full_step", 32'(o_sec), 32'(10 + k));
        end

        // Capture while viewing the last slot: index stays, shows newest
        set_time(0, 0, 16, 6);
        pulse(1, 0, 0); idle(1);
        check_val("vcap_idx", 32'(o_lap_idx), 32'd3);
        check_val("vcap_sec", 32'(o_sec), 32'd16);
        check_val("vcap_viewing", 32'(o_viewing), 32'd1);

        // Lap and next together: wrap uses pre-capture count
        i_view = 1'b0;
        pulse(0, 0, 1);
        set_time(0, 0, 21, 1); pulse(1, 0, 0);
        set_time(0, 0, 22, 2); pulse(1, 0, 0);
        i_view = 1'b1;
        idle(3);
        pulse(0, 1, 0);
        set_time(0, 0, 23, 3);
        pulse(1, 1, 0); idle(1);
        check_val("lapnext_idx", 32'(o_lap_idx), 32'd0);
        check_val("lapnext_cnt", 32'(o_lap_cnt), 32'd3);
        check_val("lapnext_sec", 32'(o_sec), 32'd21);

        // Clear and lap together: clear wins, empty view shows zero
        i_view = 1'b0;
        pulse(0, 0, 1);
        set_time(1, 2, 3, 4); pulse(1, 0, 0);
        set_time(1, 2, 5, 6); pulse(1, 0, 0);
        pulse(1, 0, 1);
        i_view = 1'b1;
        idle(3);
        check_val("clr_cnt", 32'(o_lap_cnt), 32'd0);
        check_val("clr_word", {8'h0, o_hour, o_min, o_sec, o_msec}, 32'd0);
        pulse(0, 1, 0); idle(1);
        check_val("clr_next_idx", 32'(o_lap_idx), 32'd0);
        check_val("clr_next_sec", 32'(o_sec), 32'd0);

        // Random traffic, including reset during capture
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            i_lap   = ($urandom_range(0, 3) == 0);
            i_next  = ($urandom_range(0, 2) == 0);
            i_clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) i_view = ~i_view;
            set_time($urandom_range(0, 31), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 127));
            @(negedge clk);
        end
        rst = 1'b0;
        i_lap = 1'b0;
        i_next = 1'b0;
        i_clear = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
